// File: rtl/router_pkg.sv
// Shared definitions for the router egress path.
// Contents: byte/length widths, header field offsets, one-hot FSM state
// encoding for the egress arbiter, and a modulo-3 index increment helper
// used by the round-robin picker.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;

  // Header byte layout: destination address in [1:0], payload length in [7:2].
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;

  // One-hot arbiter states. The spare code is never entered on purpose; any
  // non-listed pattern falls back to IDLE.
  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_READ    = 6'b000010;
  localparam logic [5:0] S_CAPTURE = 6'b000100;
  localparam logic [5:0] S_SEND    = 6'b001000;
  localparam logic [5:0] S_DONE    = 6'b010000;
  localparam logic [5:0] S_SPARE   = 6'b100000;

  typedef logic [1:0] port_t;

  // Next FIFO index in the cyclic order 0 -> 1 -> 2 -> 0. An out-of-range
  // index (3) is treated like 2 so the order restarts at 0.
  function automatic port_t rr_next(input port_t idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/router_egress_arbiter_if.sv
// Egress link bundle: one byte per transfer with valid/ready handshake plus
// packet framing (sop/eop) and an abort pulse.
//   master: drives egress_data/valid/sop/eop/abort, samples egress_ready
//   slave : samples the byte and framing, drives egress_ready
interface router_egress_arbiter_if #(
  parameter int DATA_W = router_pkg::DATA_W
) ();

  logic [DATA_W-1:0] egress_data;
  logic              egress_valid;
  logic              egress_sop;
  logic              egress_eop;
  logic              egress_abort;
  logic              egress_ready;

  modport master (
    output egress_data, egress_valid, egress_sop, egress_eop, egress_abort,
    input  egress_ready
  );

  modport slave (
    input  egress_data, egress_valid, egress_sop, egress_eop, egress_abort,
    output egress_ready
  );

endinterface

// File: rtl/router_rr_pick.sv
// Combinational 3-way round-robin picker.
//   req[2:0]  : request per FIFO
//   last[1:0] : index granted most recently (lowest priority next)
//   pick[1:0] : first requester in order last+1, last+2, last (mod 3)
//   any       : at least one request present
// pick is 0 when nothing is requesting.
module router_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);
  import router_pkg::*;

  port_t       last_c;
  port_t       cand [3];
  logic  [2:0] hit;

  assign last_c  = (last > 2'd2) ? 2'd2 : last;
  assign cand[0] = rr_next(last_c);
  assign cand[1] = rr_next(cand[0]);
  assign cand[2] = last_c;
  assign any     = |req;

  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    assign hit[gi] = req[cand[gi]];
  end

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    pick = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (hit[i]) pick = cand[i];
    end
  end

endmodule

// File: rtl/router_egress_arbiter.sv
// Packet-granular round-robin arbiter draining three router output FIFOs
// onto one egress link. A FIFO owns the link from its header byte to its
// parity byte; priority then rotates. A soft reset of the owning FIFO
// aborts the packet in flight.
// Ports:
//   clock, resetn              : clock, asynchronous active-low reset
//   valid_out_x                : FIFO x non-empty
//   data_out_x                 : FIFO x read data (cycle after read_enb_x)
//   soft_reset_x               : FIFO x flushed this cycle
//   read_enb_x                 : FIFO x pop strobe, at most one high
//   grant                      : index of owning FIFO, held while idle
//   busy                       : arbiter not idle
//   egress (master)            : byte, valid/ready, sop, eop, abort pulse
module router_egress_arbiter #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              valid_out_0,
  input  logic              valid_out_1,
  input  logic              valid_out_2,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [1:0]        grant,
  output logic              busy,
  router_egress_arbiter_if.master egress
);
  import router_pkg::*;

  localparam logic [LEN_W:0] CNT_ONE = 1;

  logic [2:0]        req_vec;
  logic [2:0]        soft_vec;
  logic [2:0]        rd_vec;
  logic [2:0]        grant_oh;

  logic [5:0]        state_reg, state_next;
  logic [1:0]        grant_reg;
  logic [1:0]        rr_last_reg;
  logic [LEN_W:0]    remaining_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg, sop_reg, eop_reg, abort_reg;

  logic [1:0]        pick;
  logic              any_req;
  logic              g_valid, g_soft, in_packet, flush, is_hdr;
  logic [DATA_W-1:0] g_data;
  logic [LEN_W-1:0]  hdr_len;

  assign req_vec  = {valid_out_2, valid_out_1, valid_out_0};
  assign soft_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

  router_rr_pick u_pick (
    .req  (req_vec),
    .last (rr_last_reg),
    .pick (pick),
    .any  (any_req)
  );

  // Pop strobe only in READ, only for the owner, and never in a cycle where
  // that FIFO is being flushed.
  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    assign grant_oh[gi] = (grant_reg == 2'(gi));
    assign rd_vec[gi]   = (state_reg == S_READ) & grant_oh[gi] &
                          req_vec[gi] & ~soft_vec[gi];
  end

  assign read_enb_0 = rd_vec[0];
  assign read_enb_1 = rd_vec[1];
  assign read_enb_2 = rd_vec[2];

  assign g_valid = |(req_vec & grant_oh);
  assign g_soft  = |(soft_vec & grant_oh);

  always_comb begin
    g_data = '0;
    case (grant_reg)
      2'd0:    g_data = data_out_0;
      2'd1:    g_data = data_out_1;
      2'd2:    g_data = data_out_2;
      default: g_data = '0;
    endcase
  end

  assign in_packet = (state_reg == S_READ) || (state_reg == S_CAPTURE) ||
                     (state_reg == S_SEND);
  assign flush     = in_packet && g_soft;

  // A zero remaining count means the next captured byte starts a packet.
  assign is_hdr  = (remaining_reg == '0);
  assign hdr_len = g_data[LEN_LSB +: LEN_W];

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (any_req) state_next = S_READ;
        S_READ:    if (g_valid) state_next = S_CAPTURE;
        S_CAPTURE: state_next = S_SEND;
        S_SEND:    if (egress.egress_ready) state_next = eop_reg ? S_DONE : S_READ;
        S_DONE:    state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      grant_reg     <= 2'd0;
      rr_last_reg   <= 2'd2;
      remaining_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      sop_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      abort_reg <= 1'b0;
      if (flush) begin
        // Aborted owner drops to lowest priority; framing restarts clean.
        valid_reg     <= 1'b0;
        abort_reg     <= 1'b1;
        rr_last_reg   <= grant_reg;
        remaining_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (any_req) grant_reg <= pick;
          end
          S_CAPTURE: begin
            data_reg  <= g_data;
            valid_reg <= 1'b1;
            if (is_hdr) begin
              // Payload bytes plus the trailing parity byte.
              remaining_reg <= {1'b0, hdr_len} + CNT_ONE;
              sop_reg       <= 1'b1;
              eop_reg       <= 1'b0;
            end else begin
              remaining_reg <= remaining_reg - CNT_ONE;
              sop_reg       <= 1'b0;
              eop_reg       <= (remaining_reg == CNT_ONE);
            end
          end
          S_SEND: begin
            if (egress.egress_ready) valid_reg <= 1'b0;
          end
          S_DONE: begin
            rr_last_reg <= grant_reg;
          end
          default: ;
        endcase
      end
    end
  end

  assign grant               = grant_reg;
  assign busy                = (state_reg != S_IDLE);
  assign egress.egress_data  = data_reg;
  assign egress.egress_valid = valid_reg;
  assign egress.egress_sop   = sop_reg;
  assign egress.egress_eop   = eop_reg;
  assign egress.egress_abort = abort_reg;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: three behavioural FIFOs feed the
// arbiter, a monitor logs every accepted egress byte, and packets are
// compared byte by byte against the bytes that were pushed.
module tb_router_egress_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        valid_out_0, valid_out_1, valid_out_2;
  logic [7:0]  data_out_0, data_out_1, data_out_2;
  logic        soft_reset_0, soft_reset_1, soft_reset_2;
  logic        read_enb_0, read_enb_1, read_enb_2;
  logic [1:0]  grant;
  logic        busy;

  router_egress_arbiter_if #(.DATA_W(8)) eg_if ();

  router_egress_arbiter #(.DATA_W(8), .LEN_W(6)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .valid_out_0  (valid_out_0),
    .valid_out_1  (valid_out_1),
    .valid_out_2  (valid_out_2),
    .data_out_0   (data_out_0),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .grant        (grant),
    .busy         (busy),
    .egress       (eg_if)
  );

  always #5 clock = ~clock;

  // ---------------- FIFO models ----------------
  logic [7:0] mem [3][256];
  logic [7:0] wr_ptr [3];
  logic [7:0] rd_ptr [3];
  logic [7:0] fifo_dout [3];
  logic [2:0] soft_vec, rd_vec;

  assign soft_vec    = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign rd_vec      = {read_enb_2, read_enb_1, read_enb_0};
  assign valid_out_0 = (rd_ptr[0] != wr_ptr[0]);
  assign valid_out_1 = (rd_ptr[1] != wr_ptr[1]);
  assign valid_out_2 = (rd_ptr[2] != wr_ptr[2]);
  assign data_out_0  = fifo_dout[0];
  assign data_out_1  = fifo_dout[1];
  assign data_out_2  = fifo_dout[2];

  always @(posedge clock) begin
    for (int f = 0; f < 3; f++) begin
      if (!resetn || soft_vec[f]) begin
        rd_ptr[f] <= wr_ptr[f];
      end else if (rd_vec[f]) begin
        fifo_dout[f] <= mem[f][rd_ptr[f]];
        rd_ptr[f]    <= rd_ptr[f] + 8'd1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [11:0] log_q [$];
  int rd_cnt [3];
  int busy_cnt  = 0;
  int multi_err = 0;

  always @(negedge clock) begin
    if (eg_if.egress_valid && eg_if.egress_ready)
      log_q.push_back({grant, eg_if.egress_sop, eg_if.egress_eop, eg_if.egress_data});
    if (({2'b0, read_enb_0} + {2'b0, read_enb_1} + {2'b0, read_enb_2}) > 3'd1)
      multi_err <= multi_err + 1;
    for (int f = 0; f < 3; f++) if (rd_vec[f]) rd_cnt[f] <= rd_cnt[f] + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  int cur   = 0;
  logic [7:0] seed = 8'h30;
  logic [7:0] exp_q [3][$];
  logic [7:0] stage_q [3][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_pkt(input int f, input logic [7:0] hdr);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    exp_q[f].push_back(hdr);
    stage_q[f].push_back(hdr);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      seed = seed + 8'd7;
      b    = seed;
      par  = par ^ b;
      exp_q[f].push_back(b);
      stage_q[f].push_back(b);
    end
    exp_q[f].push_back(par);
    stage_q[f].push_back(par);
  endtask

  task automatic push_bytes(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      mem[f][wr_ptr[f]] = stage_q[f].pop_front();
      wr_ptr[f] = wr_ptr[f] + 8'd1;
    end
  endtask

  task automatic push_pkt(input int f, input logic [7:0] hdr);
    make_pkt(f, hdr);
    push_bytes(f, int'(hdr[7:2]) + 2);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_log(input int n);
    int budget;
    budget = 400;
    while (log_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (log_q.size() < n) check("log_timeout", log_q.size(), n);
  endtask

  task automatic wait_valid();
    int budget;
    budget = 100;
    while (!eg_if.egress_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (!eg_if.egress_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic pulse_ready();
    eg_if.egress_ready = 1'b1;
    tick();
    eg_if.egress_ready = 1'b0;
  endtask

  task automatic check_pkt(input int f, input logic [7:0] hdr);
    int         n;
    logic [1:0] f2;
    logic [7:0] b;
    logic [11:0] obs;
    n  = int'(hdr[7:2]) + 2;
    f2 = f[1:0];
    wait_log(cur + n);
    for (int i = 0; i < n; i++) begin
      b   = (exp_q[f].size() > 0) ? exp_q[f].pop_front() : 8'h00;
      obs = (cur + i < log_q.size()) ? log_q[cur + i] : 12'h000;
      check($sformatf("pkt_f%0d_b%0d", f, i), {20'd0, obs},
            {20'd0, f2, (i == 0), (i == n - 1), b});
    end
    cur = cur + n;
    $display("packet fifo=%0d hdr=%02h bytes=%0d", f, hdr, n);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int f = 0; f < 3; f++) begin
      exp_q[f].delete();
      stage_q[f].delete();
    end
    repeat (3) tick();
    cur = log_q.size();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, a0;
    for (int f = 0; f < 3; f++) begin
      wr_ptr[f] = 8'd0;
      rd_cnt[f] = 0;
    end
    soft_reset_0 = 1'b0;
    soft_reset_1 = 1'b0;
    soft_reset_2 = 1'b0;
    eg_if.egress_ready = 1'b0;
    do_reset();

    // Reset state.
    check("rst_valid", {31'd0, eg_if.egress_valid}, 0);
    check("rst_sop",   {31'd0, eg_if.egress_sop}, 0);
    check("rst_eop",   {31'd0, eg_if.egress_eop}, 0);
    check("rst_abort", {31'd0, eg_if.egress_abort}, 0);
    check("rst_data",  {24'd0, eg_if.egress_data}, 0);
    check("rst_grant", {30'd0, grant}, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_rd",    {29'd0, rd_vec}, 0);
    resetn = 1'b1;
    tick();

    // Single len-3 packet on FIFO 1 with ready held high.
    eg_if.egress_ready = 1'b1;
    b0 = busy_cnt;
    r0 = rd_cnt[1];
    push_pkt(1, 8'h0D);
    check_pkt(1, 8'h0D);
    repeat (4) tick();
    check("t1_reads", rd_cnt[1] - r0, 5);
    check("t1_busy_cycles", busy_cnt - b0, 16);

    // All three FIFOs loaded with two len-1 packets from reset.
    do_reset();
    resetn = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      push_pkt(0, 8'h04);
      push_pkt(1, 8'h05);
      push_pkt(2, 8'h06);
    end
    for (int k = 0; k < 2; k++) begin
      check_pkt(0, 8'h04);
      check_pkt(1, 8'h05);
      check_pkt(2, 8'h06);
    end
    repeat (3) tick();

    // Back-pressure: ready low for 4 cycles on the first payload byte.
    eg_if.egress_ready = 1'b0;
    push_pkt(0, 8'h08);
    wait_valid();
    pulse_ready();
    wait_valid();
    r0 = rd_cnt[0];
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_valid", {31'd0, eg_if.egress_valid}, 1);
      check("t3_hold_data", {24'd0, eg_if.egress_data}, {24'd0, exp_q[0][1]});
      tick();
    end
    check("t3_no_read", rd_cnt[0] - r0, 0);
    eg_if.egress_ready = 1'b1;
    check_pkt(0, 8'h08);
    repeat (3) tick();

    // FIFO 2 underflows after its header for 6 cycles.
    r0 = rd_cnt[2];
    make_pkt(2, 8'h0A);
    push_bytes(2, 1);
    wait_log(cur + 1);
    for (int i = 0; i < 6; i++) begin
      check("t4_rd2_idle", {31'd0, read_enb_2}, 0);
      check("t4_valid_low", {31'd0, eg_if.egress_valid}, 0);
      tick();
    end
    push_bytes(2, 3);
    check_pkt(2, 8'h0A);
    check("t4_reads", rd_cnt[2] - r0, 4);
    repeat (3) tick();

    // Soft reset of FIFO 0 while its payload byte 2 waits in SEND.
    eg_if.egress_ready = 1'b0;
    push_pkt(0, 8'h0C);
    push_pkt(1, 8'h05);
    wait_valid();
    pulse_ready();
    wait_valid();
    pulse_ready();
    wait_valid();
    check("t5_p2_data", {24'd0, eg_if.egress_data}, {24'd0, exp_q[0][2]});
    check("t5_owner", {30'd0, grant}, 0);
    soft_reset_0 = 1'b1;
    tick();
    soft_reset_0 = 1'b0;
    check("t5_valid_drop", {31'd0, eg_if.egress_valid}, 0);
    check("t5_abort_hi", {31'd0, eg_if.egress_abort}, 1);
    check("t5_idle", {31'd0, busy}, 0);
    exp_q[0].delete();
    cur = cur + 2;
    tick();
    check("t5_abort_lo", {31'd0, eg_if.egress_abort}, 0);
    check("t5_next_grant", {30'd0, grant}, 1);
    eg_if.egress_ready = 1'b1;
    check_pkt(1, 8'h05);
    repeat (3) tick();

    // Zero-length header: header plus parity only.
    push_pkt(0, 8'h00);
    check_pkt(0, 8'h00);
    repeat (3) tick();

    // Reset in the middle of a FIFO 1 packet.
    push_pkt(1, 8'h0D);
    wait_log(cur + 2);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, eg_if.egress_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_grant", {30'd0, grant}, 0);
    check("t6_rst_rd", {29'd0, rd_vec}, 0);
    check("t6_rst_data", {24'd0, eg_if.egress_data}, 0);
    do_reset();
    resetn = 1'b1;
    tick();
    a0 = 0;
    push_pkt(1, 8'h01);
    push_pkt(0, 8'h00);
    check_pkt(0, 8'h00);
    check_pkt(1, 8'h01);
    repeat (4) tick();
    check("no_multi_read", multi_err, a0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
